// File: rtl/dec24_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
//   req[3:0]     requester -> arbiter, level request per requester
//   done[3:0]    requester -> arbiter, release pulse per requester
//   gnt[3:0]     arbiter -> requesters, one-hot decode of {gnt_vld, gnt_idx}
//   gnt_idx[1:0] arbiter -> requesters, encoded owner index (decoder a)
//   gnt_vld      arbiter -> requesters, grant active (decoder e)
//   timeout      arbiter -> requesters, one-cycle forced-release pulse
interface dec24_rr_arbiter_if;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             timeout;

  // Requester side.
  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_vld,
    input  timeout
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_vld,
    output timeout
  );
endinterface

// File: rtl/dec24_rr_arbiter.sv
// Four-requester round-robin arbiter driving a 2x4-decoder-selected resource.
// A grant is held until the owner pulses done, drops req, or the hold timer
// expires; priority then rotates to the requester after the released owner.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of dec24_rr_arbiter_if (req/done in, grant signals out)
module dec24_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dec24_rr_arbiter_if.slave     bus
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  // Counter value on the last permitted cycle of a grant.
  localparam logic [CNT_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              vld_q, vld_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;

  logic              pick_vld;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  cand;
  logic              rel_done, rel_req, rel_to;

  // Rotated priority search: scan farthest offset first so the nearest
  // requester to ptr overwrites and wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr_q;
    cand     = ptr_q;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr_q + IDX_W'(k);
      if (bus.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Release sources; only the owner's lines matter.
  always_comb begin
    rel_done = bus.done[idx_q];
    rel_req  = ~bus.req[idx_q];
    rel_to   = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    vld_d     = vld_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    gnt_d     = '0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BUSY;
          idx_d   = pick_idx;
          vld_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (rel_done || rel_req || rel_to) begin
          state_d   = IDLE;
          vld_d     = 1'b0;
          ptr_d     = idx_q + IDX_W'(1);
          timeout_d = rel_to && !rel_done && !rel_req;
        end else if (cnt_q != '1) begin
          // Saturating so an unbounded hold (MAX_HOLD=0) never wraps.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase

    // 2x4 decode of {e, a}; registered so gnt is glitch-free.
    if (vld_d) begin
      gnt_d = N_REQ'(1) << idx_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      vld_q     <= 1'b0;
      gnt_q     <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      vld_q     <= vld_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.gnt_vld = vld_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_dec24_rr_arbiter.sv
// Self-checking bench for dec24_rr_arbiter (MAX_HOLD=16). Expected grants are
// queued when requests are driven and popped when the grant is observed.
module tb_dec24_rr_arbiter;

  logic clk;
  logic rst_n;

  dec24_rr_arbiter_if bus ();

  dec24_rr_arbiter #(
    .MAX_HOLD (16),
    .CNT_W    (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] pop_exp();
    if (exp_q.size() == 0) return 4'bxxxx;
    return exp_q.pop_front();
  endfunction

  task automatic reset_dut();
    bus.req  = 4'b0000;
    bus.done = 4'b0000;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    bus.req  = 4'b0000;
    bus.done = 4'b0000;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.timeout} !== 8'b0000_00_0_0) begin
      n_fail++;
      $display("FAIL reset_vals: got gnt=%b idx=%b vld=%b to=%b want all zero",
               bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.timeout);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.gnt, bus.gnt_vld, bus.timeout} !== 6'b0000_0_0) begin
        n_fail++;
        $display("FAIL idle_c%0d: got gnt=%b vld=%b to=%b want 0000/0/0",
                 c, bus.gnt, bus.gnt_vld, bus.timeout);
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] e;
    reset_dut();
    bus.req = 4'b0100;
    exp_q.push_back(4'b0100);
    @(negedge clk);
    e = pop_exp();
    n_tests++;
    if ({bus.gnt, bus.gnt_idx} !== {e, 2'b10}) begin
      n_fail++;
      $display("FAIL single_gnt: got gnt=%b idx=%b want %b/10", bus.gnt, bus.gnt_idx, e);
    end
    bus.done = 4'b0100;
    @(negedge clk);
    bus.done = 4'b0000;
    n_tests++;
    if ({bus.gnt, bus.gnt_vld, bus.timeout} !== 6'b0000_0_0) begin
      n_fail++;
      $display("FAIL single_release: got gnt=%b vld=%b to=%b want 0000/0/0",
               bus.gnt, bus.gnt_vld, bus.timeout);
    end
    exp_q.push_back(4'b0100);
    @(negedge clk);
    e = pop_exp();
    n_tests++;
    if (bus.gnt !== e) begin
      n_fail++;
      $display("FAIL single_regrant: got %b want %b", bus.gnt, e);
    end
    bus.req = 4'b0000;
    @(negedge clk);
    n_tests++;
    if (bus.gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_req_drop: got %b want 0000", bus.gnt);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] e;
    reset_dut();
    bus.req = 4'b1111;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      e = pop_exp();
      n_tests++;
      if (bus.gnt !== e) begin
        n_fail++;
        $display("FAIL rot_gnt%0d: got %b want %b", g, bus.gnt, e);
      end
      for (int h = 1; h <= 2; h++) begin
        @(negedge clk);
        n_tests++;
        if (bus.gnt !== e) begin
          n_fail++;
          $display("FAIL rot_hold%0d_%0d: got %b want %b", g, h, bus.gnt, e);
        end
      end
      bus.done = e;
      @(negedge clk);
      bus.done = 4'b0000;
      n_tests++;
      if (bus.gnt !== 4'b0000) begin
        n_fail++;
        $display("FAIL rot_dead%0d: got %b want 0000", g, bus.gnt);
      end
    end
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [3:0] e;
    reset_dut();
    bus.req = 4'b0010;
    exp_q.push_back(4'b0010);
    e = pop_exp();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.gnt, bus.timeout} !== {e, 1'b0}) begin
        n_fail++;
        $display("FAIL to_hold%0d: got gnt=%b to=%b want %b/0", k, bus.gnt, bus.timeout, e);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({bus.gnt, bus.timeout} !== 5'b0000_1) begin
      n_fail++;
      $display("FAIL to_fire: got gnt=%b to=%b want 0000/1", bus.gnt, bus.timeout);
    end
    bus.req = 4'b0011;
    exp_q.push_back(4'b0001);
    @(negedge clk);
    e = pop_exp();
    n_tests++;
    if ({bus.gnt, bus.timeout} !== {e, 1'b0}) begin
      n_fail++;
      $display("FAIL to_wrap: got gnt=%b to=%b want %b/0", bus.gnt, bus.timeout, e);
    end
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic [3:0] e;
    reset_dut();
    bus.req = 4'b0001;
    exp_q.push_back(4'b0001);
    e = pop_exp();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      n_tests++;
      if (bus.gnt !== e) begin
        n_fail++;
        $display("FAIL sim_hold%0d: got %b want %b", k, bus.gnt, e);
      end
      if (k == 5) bus.done = 4'b1110;
      if (k == 6) bus.done = 4'b0000;
      if (k == 8) bus.req = 4'b1111;
      if (k == 16) bus.done = 4'b0001;
    end
    @(negedge clk);
    bus.done = 4'b0000;
    n_tests++;
    if ({bus.gnt, bus.timeout} !== 5'b0000_0) begin
      n_fail++;
      $display("FAIL sim_release: got gnt=%b to=%b want 0000/0", bus.gnt, bus.timeout);
    end
    // Owner 0 released, so requester 1 is next in rotation.
    exp_q.push_back(4'b0010);
    @(negedge clk);
    e = pop_exp();
    n_tests++;
    if (bus.gnt !== e) begin
      n_fail++;
      $display("FAIL sim_next: got %b want %b", bus.gnt, e);
    end
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [3:0] e;
    reset_dut();
    bus.req = 4'b0010;
    @(negedge clk);
    bus.req = 4'b0000;
    @(negedge clk);
    // ptr is now 2; requester 3 wins.
    bus.req = 4'b1000;
    exp_q.push_back(4'b1000);
    @(negedge clk);
    e = pop_exp();
    n_tests++;
    if (bus.gnt !== e) begin
      n_fail++;
      $display("FAIL mid_pre: got %b want %b", bus.gnt, e);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.gnt, bus.gnt_vld, bus.gnt_idx} !== 7'b0000_0_00) begin
      n_fail++;
      $display("FAIL mid_async: got gnt=%b vld=%b idx=%b want 0000/0/00",
               bus.gnt, bus.gnt_vld, bus.gnt_idx);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 4'b1001;
    exp_q.push_back(4'b0001);
    @(negedge clk);
    e = pop_exp();
    n_tests++;
    if (bus.gnt !== e) begin
      n_fail++;
      $display("FAIL mid_ptr0: got %b want %b", bus.gnt, e);
    end
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 4'b0000;
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dec24_rr_arbiter.md
Name: dec24_rr_arbiter

Overview:
Four-requester round-robin arbiter that shares one 2x4 decoder-driven resource, such as a bus or register bank selected by a one-hot line. It registers a 2-bit grant index plus an enable and presents the decoded one-hot grant. That matches the e/a -> d[3:0] convention of the team's 2x4 decoder, with e as bit 2 above a[1:0]. Each grant is held until the owner releases or a hold timeout fires, and priority then rotates.

Parameters:
MAX_HOLD, 16, maximum cycles a grant may be held before a forced release; 0 disables the timeout.
CNT_W, 5, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  4  request per requester, level; req[i] stays high while requester i wants or holds the resource.
done  input  4  release pulse per requester; only done[gnt_idx] is honoured.
gnt  output  4  one-hot grant; decoder output of {gnt_vld, gnt_idx}, all zero when gnt_vld=0.
gnt_idx  output  2  encoded index of the current owner (decoder a input).
gnt_vld  output  1  grant active (decoder e input).
timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (rst_n=0, asynchronous and immediate, including mid-grant):
  - gnt=0000, gnt_idx=00, gnt_vld=0, timeout=0.
  - state=IDLE, hold counter=0, rotate pointer ptr=0 (requester 0 has highest priority).
- States: IDLE, BUSY.
- IDLE:
  - If req != 0, select the first i with req[i]=1, searching ptr, ptr+1, ... mod 4.
  - At the next edge: gnt_idx=i, gnt_vld=1, hold counter=0, state=BUSY.
  - Latency is one cycle from req seen high in IDLE to gnt high.
  - If req = 0, stay in IDLE with outputs at their reset values (timeout is 0 in IDLE except as stated under Release).
- BUSY: outputs are held stable and the hold counter increments every cycle. The grant releases at the next edge when any of these holds:
  - (a) done[gnt_idx]=1.
  - (b) req[gnt_idx]=0.
  - (c) MAX_HOLD != 0 and hold counter == MAX_HOLD-1.
- Release: gnt_vld=0, gnt=0000, ptr=gnt_idx+1 mod 4 (wraps 3->0), state=IDLE.
  - gnt_idx keeps its last value while gnt_vld=0.
  - timeout=1 for exactly that one cycle, only if (c) caused the release and neither (a) nor (b) was also true.
- Dead cycle: after any release, gnt is 0000 for at least one full cycle before the next grant. Back-to-back ownership changes are therefore never glitch-adjacent.
- done on non-owner lines and done while IDLE are ignored.
- req changes on non-owner lines during BUSY have no effect until the next IDLE.
- A requester that was just released may be re-granted only if no other requester at a rotated priority ahead of it is requesting.
- gnt always equals the 2x4 decode of {gnt_vld, gnt_idx}: exactly one bit set when gnt_vld=1, zero otherwise. X-free after reset.
- Hold counter saturates, never wraps, when MAX_HOLD=0.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, release it, req=0000 for 5 cycles -> gnt=0000, gnt_vld=0, timeout=0 throughout.
- Single requester: req=0100 -> gnt=0100, gnt_idx=10 one cycle later. done=0100 pulse -> gnt=0000 next cycle, then gnt=0100 again after one dead cycle with req still high.
- Round-robin rotation: req=1111 held, each owner pulses done 3 cycles after being granted -> grant order 0001, 0010, 0100, 1000, 0001, with exactly one zero cycle between consecutive grants.
- Timeout: MAX_HOLD=16, req=0010 held, no done -> gnt=0010 for exactly 16 cycles, then timeout=1 and gnt=0000 in the same cycle. With req=0011, the next grant is 0001 (ptr=2 wraps to requester 0).
- Simultaneous release sources: done[owner]=1 on the cycle hold counter hits MAX_HOLD-1 -> release with timeout=0. done on a non-owner line -> no change.
- Reset mid-grant: assert rst_n=0 asynchronously while gnt=1000 -> gnt=0000 immediately, before the next edge. After release, req=1001 -> gnt=0001 (ptr back to 0).
